mips32_mem_arbiter: RTL and testbench



---
 rtl/mips32_pkg.sv | 15 +
 rtl/mips32_starve_ctr.sv | 28 ++
 rtl/mips32_mem_arbiter.sv | 96 +++++++++
 tb/tb_mips32_mem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: default bus widths and the requester IDs used
// for memory response routing.
package mips32_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2,
      OWN_DBG  = 2'd3
   } owner_e;

endpackage

// File: rtl/mips32_starve_ctr.sv
// Saturating count of consecutive instruction-fetch denials; the starved flag
// lets fetch win against the data stage.
module mips32_starve_ctr #(
   parameter int MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] cnt,
   output logic       starved
);

   localparam logic [3:0] MAX_C = 4'(MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 4'd0;
      end else if (clr) begin
         cnt <= 4'd0;
      end else if (inc && !starved) begin
         cnt <= cnt + 4'd1;
      end
   end

   assign starved = (cnt == MAX_C);

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter for IF, DM and DBG with a one-cycle read
// response routed back to the requester that issued it.
module mips32_mem_arbiter
   import mips32_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   owner_e     resp_owner;
   owner_e     resp_next;
   logic [3:0] starve_cnt;
   logic       starved;

   mips32_starve_ctr #(
      .MAX(STARVE_MAX)
   ) u_starve (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (!if_req || if_gnt),
      .inc    (if_req && !if_gnt),
      .cnt    (starve_cnt),
      .starved(starved)
   );

   // Grants are gated by rst_n so nothing reaches memory while in reset.
   assign dbg_gnt = rst_n && dbg_req;
   assign dm_gnt  = rst_n && dm_req && !dbg_req && !(starved && if_req);
   assign if_gnt  = rst_n && if_req && !dbg_req && (!dm_req || starved);
   assign mem_en  = if_gnt || dm_gnt || dbg_gnt;

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      resp_next = OWN_NONE;
      if (dbg_gnt) begin
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
         resp_next = dbg_we ? OWN_NONE : OWN_DBG;
      end else if (dm_gnt) begin
         mem_we    = dm_we;
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
         resp_next = dm_we ? OWN_NONE : OWN_DM;
      end else if (if_gnt) begin
         mem_addr  = if_addr;
         resp_next = OWN_IF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_owner <= OWN_NONE;
      end else begin
         resp_owner <= resp_next;
      end
   end

   assign if_rvalid  = (resp_owner == OWN_IF);
   assign dm_rvalid  = (resp_owner == OWN_DM);
   assign dbg_rvalid = (resp_owner == OWN_DBG);
   assign if_rdata   = mem_rdata;
   assign dm_rdata   = mem_rdata;
   assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Scoreboard bench for mips32_mem_arbiter: a reference arbiter and memory
// image predict grants and read responses cycle by cycle.
module tb_mips32_mem_arbiter;
   import mips32_pkg::*;

   localparam int AW = DEF_ADDR_W;
   localparam int DW = DEF_DATA_W;
   localparam int SMAX = 4;

   typedef struct {
      owner_e        owner;
      logic [DW-1:0] data;
      int            due;
   } resp_t;

   logic          clk;
   logic          rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt, if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          dm_req, dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_gnt, dm_rvalid;
   logic [DW-1:0] dm_rdata;
   logic          dbg_req, dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_gnt, dbg_rvalid;
   logic [DW-1:0] dbg_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic [DW-1:0] mem    [0:(1<<AW)-1];
   logic [DW-1:0] refMem [0:(1<<AW)-1];
   resp_t         sbQ[$];
   int            checkCount = 0;
   int            passCount  = 0;
   int            cycleNo    = 0;
   int            mStarve    = 0;
   logic [DW-1:0] prog [0:8];
   logic [9:0]    ifGntTrace;

   mips32_mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port memory behind the arbiter.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected)
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, observed, expected, cycleNo);
      else
         passCount++;
   endtask

   // Drive one cycle, predict winner and response, and update the model.
   task automatic applyStimulus(
      input logic iReq, input logic [AW-1:0] iAddr,
      input logic dReq, input logic dWe, input logic [AW-1:0] dAddr, input logic [DW-1:0] dWd,
      input logic gReq, input logic gWe, input logic [AW-1:0] gAddr, input logic [DW-1:0] gWd);
      owner_e        expWin;
      owner_e        expOwn;
      logic          expWe;
      logic [AW-1:0] expAddr;
      logic [DW-1:0] expWd;
      logic [DW-1:0] expData;
      resp_t         e;
      @(negedge clk);
      if_req = iReq;  if_addr = iAddr;
      dm_req = dReq;  dm_we = dWe;   dm_addr = dAddr;   dm_wdata = dWd;
      dbg_req = gReq; dbg_we = gWe;  dbg_addr = gAddr;  dbg_wdata = gWd;
      #2;
      expWe = 1'b0; expAddr = '0; expWd = '0;
      if (gReq) begin
         expWin = OWN_DBG; expWe = gWe; expAddr = gAddr; expWd = gWd;
      end else if (dReq && !(iReq && mStarve == SMAX)) begin
         expWin = OWN_DM; expWe = dWe; expAddr = dAddr; expWd = dWd;
      end else if (iReq) begin
         expWin = OWN_IF; expAddr = iAddr;
      end else begin
         expWin = OWN_NONE;
      end
      checkOutput("if_gnt",  32'(if_gnt),  32'(expWin == OWN_IF));
      checkOutput("dm_gnt",  32'(dm_gnt),  32'(expWin == OWN_DM));
      checkOutput("dbg_gnt", 32'(dbg_gnt), 32'(expWin == OWN_DBG));
      checkOutput("gnt_onehot", 32'($countones({if_gnt, dm_gnt, dbg_gnt}) <= 1), 32'd1);
      checkOutput("mem_en",  32'(mem_en),  32'(expWin != OWN_NONE));
      checkOutput("mem_we",  32'(mem_we),  32'(expWe));
      checkOutput("mem_addr", 32'(mem_addr), 32'(expAddr));
      checkOutput("mem_wdata", mem_wdata, expWd);

      expOwn = OWN_NONE; expData = '0;
      if (sbQ.size() > 0 && sbQ[0].due == cycleNo) begin
         e = sbQ.pop_front();
         expOwn = e.owner; expData = e.data;
      end
      checkOutput("if_rvalid",  32'(if_rvalid),  32'(expOwn == OWN_IF));
      checkOutput("dm_rvalid",  32'(dm_rvalid),  32'(expOwn == OWN_DM));
      checkOutput("dbg_rvalid", 32'(dbg_rvalid), 32'(expOwn == OWN_DBG));
      case (expOwn)
         OWN_IF:  checkOutput("if_rdata",  if_rdata,  expData);
         OWN_DM:  checkOutput("dm_rdata",  dm_rdata,  expData);
         OWN_DBG: checkOutput("dbg_rdata", dbg_rdata, expData);
         default: ;
      endcase

      if (expWin != OWN_NONE) begin
         if (expWe) refMem[expAddr] = expWd;
         else sbQ.push_back('{owner: expWin, data: refMem[expAddr], due: cycleNo + 1});
      end
      if (iReq && expWin != OWN_IF) mStarve = (mStarve < SMAX) ? mStarve + 1 : SMAX;
      else mStarve = 0;
      cycleNo++;
   endtask

   // Hold reset with every requester asking; nothing may be granted or returned.
   task automatic resetPhase(input int cycles);
      rst_n = 1'b0;
      if_req = 1'b1; dm_req = 1'b1; dbg_req = 1'b1;
      dm_we = 1'b0; dbg_we = 1'b0;
      sbQ.delete();
      mStarve = 0;
      repeat (cycles) begin
         #1;
         checkOutput("rst_gnt", 32'({if_gnt, dm_gnt, dbg_gnt}), 32'd0);
         checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
         checkOutput("rst_rvalid", 32'({if_rvalid, dm_rvalid, dbg_rvalid}), 32'd0);
         @(negedge clk);
         cycleNo++;
      end
      rst_n = 1'b1;
      if_req = 1'b0; dm_req = 1'b0; dbg_req = 1'b0;
   endtask

   initial begin
      prog[0] = 32'h2801000a; prog[1] = 32'h20020001; prog[2] = 32'h00221820;
      prog[3] = 32'h8c040010; prog[4] = 32'hac050014; prog[5] = 32'h1022fffb;
      prog[6] = 32'h00000000; prog[7] = 32'h3c0b1234; prog[8] = 32'hfc000000;
      if_addr = '0; dm_addr = '0; dm_wdata = '0; dbg_addr = '0; dbg_wdata = '0;
      resetPhase(2);

      // Load the program through DBG while IF keeps asking and starving.
      for (int i = 0; i < 9; i++)
         applyStimulus(1'b1, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(i), prog[i]);

      // IF alone streams the program back.
      for (int i = 0; i < 9; i++)
         applyStimulus(1'b1, AW'(i), 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);

      // DBG write beats IF, then IF sees the new word.
      applyStimulus(1'b1, 10'd5, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'd5, 32'h00222000);
      applyStimulus(1'b1, 10'd5, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);

      // Back-to-back DM loads: IF must break through every fifth cycle.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, AW'(i % 9), 1'b1, 1'b0, AW'((i + 3) % 9), '0, 1'b0, 1'b0, '0, '0);
         ifGntTrace[i] = if_gnt;
      end
      checkOutput("starve_pattern", 32'(ifGntTrace), 32'h210);
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 10'd7, 32'hcafef00d, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 10'd7, '0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);

      // Mixed reads: DM then IF, responses must not cross.
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 10'd3, '0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 10'd4, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);

      // Reset right after a granted DBG read: the response is dropped.
      applyStimulus(1'b1, 10'd1, 1'b1, 1'b0, 10'd2, '0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 10'd1, 1'b1, 1'b0, 10'd2, '0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 10'd1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd2, '0);
      resetPhase(1);
      #1;
      checkOutput("starve_cnt_after_rst", 32'(dut.starve_cnt), 32'd0);
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b1, 10'd0, 1'b1, 1'b0, 10'd1, '0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
